// File: rtl/mult_job_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : mult_job_scheduler
// Brief   : Round-robin scheduler for two requesters sharing a bus-attached
//           multiplier peripheral: writes operands, polls status, reads result.
// Rev     : 1.0  initial release
// ============================================================================
module mult_job_scheduler #(
    parameter int POLL_MAX = 16,
    parameter int POLL_GAP = 2
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [1:0]  req,
    input  logic [47:0] op_a1,
    input  logic [47:0] op_a2,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic [31:0] res_w,
    output logic [23:0] res_l,
    output logic        res_ok,
    output logic        res_err,
    output logic [15:0] saddress,
    output logic        swr,
    output logic        srd,
    output logic [31:0] sdata_wr,
    input  logic [31:0] sdata_rd
);

    localparam logic [15:0] c_ADDR_A1   = 16'h037F;
    localparam logic [15:0] c_ADDR_A2   = 16'h0388;
    localparam logic [15:0] c_ADDR_STAT = 16'h03A0;
    localparam logic [15:0] c_ADDR_W    = 16'h0390;
    localparam logic [15:0] c_ADDR_L    = 16'h0398;

    localparam int PW = $clog2(POLL_MAX + 1);
    localparam int GW = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_WR_A1 = 4'd1,
        S_WR_A2 = 4'd2,
        S_WR_GO = 4'd3,
        S_POLL  = 4'd4,
        S_GAP   = 4'd5,
        S_RD_W  = 4'd6,
        S_RD_L  = 4'd7,
        S_DONE  = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP  = 2'd0,
        PH_STROBE = 2'd1,
        PH_HOLD   = 2'd2
    } phase_t;

    state_t          state_q;
    phase_t          phase_q;
    logic [PW-1:0]   poll_cnt_q;
    logic [GW-1:0]   gap_cnt_q;
    logic            last_q;
    logic [23:0]     a2_q;
    logic            ok_q;
    logic [31:0]     word_q;
    logic [1:0]      gnt_q;
    logic [1:0]      done_q;
    logic [31:0]     res_w_q;
    logic [23:0]     res_l_q;
    logic            res_ok_q;
    logic            res_err_q;
    logic [15:0]     saddr_q;
    logic            swr_q;
    logic            srd_q;
    logic [31:0]     wdata_q;

    logic [1:0]      grant_d;
    logic [23:0]     sel_a1_d;
    logic [23:0]     sel_a2_d;
    logic            bus_wr_d;

    // last_q records the index served last; on a tie the other one wins
    always_comb begin
        grant_d = 2'b00;
        case (req)
            2'b01:   grant_d = 2'b01;
            2'b10:   grant_d = 2'b10;
            2'b11:   grant_d = last_q ? 2'b01 : 2'b10;
            default: grant_d = 2'b00;
        endcase
    end

    always_comb begin
        sel_a1_d = grant_d[1] ? op_a1[47:24] : op_a1[23:0];
        sel_a2_d = grant_d[1] ? op_a2[47:24] : op_a2[23:0];
        bus_wr_d = (state_q == S_WR_A1) || (state_q == S_WR_A2) || (state_q == S_WR_GO);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= S_IDLE;
            phase_q    <= PH_SETUP;
            poll_cnt_q <= '0;
            gap_cnt_q  <= '0;
            last_q     <= 1'b1;
            a2_q       <= '0;
            ok_q       <= 1'b0;
            word_q     <= '0;
            gnt_q      <= 2'b00;
            done_q     <= 2'b00;
            res_w_q    <= '0;
            res_l_q    <= '0;
            res_ok_q   <= 1'b0;
            res_err_q  <= 1'b0;
            saddr_q    <= '0;
            swr_q      <= 1'b0;
            srd_q      <= 1'b0;
            wdata_q    <= '0;
        end else begin
            done_q <= 2'b00;
            case (state_q)
                S_IDLE: begin
                    if (|req) begin
                        gnt_q   <= grant_d;
                        last_q  <= grant_d[1];
                        a2_q    <= sel_a2_d;
                        state_q <= S_WR_A1;
                        phase_q <= PH_SETUP;
                        saddr_q <= c_ADDR_A1;
                        wdata_q <= {8'h00, sel_a1_d};
                    end
                end

                S_WR_A1, S_WR_A2, S_WR_GO, S_POLL, S_RD_W, S_RD_L: begin
                    case (phase_q)
                        PH_SETUP: begin
                            phase_q <= PH_STROBE;
                            swr_q   <= bus_wr_d;
                            srd_q   <= !bus_wr_d;
                        end
                        PH_STROBE: begin
                            phase_q <= PH_HOLD;
                            swr_q   <= 1'b0;
                            srd_q   <= 1'b0;
                        end
                        default: begin
                            // end of HOLD: read data sampled here, next transaction set up
                            phase_q <= PH_SETUP;
                            case (state_q)
                                S_WR_A1: begin
                                    state_q <= S_WR_A2;
                                    saddr_q <= c_ADDR_A2;
                                    wdata_q <= {8'h00, a2_q};
                                end
                                S_WR_A2: begin
                                    state_q <= S_WR_GO;
                                    saddr_q <= c_ADDR_STAT;
                                    wdata_q <= '0;
                                end
                                S_WR_GO: begin
                                    state_q    <= S_POLL;
                                    saddr_q    <= c_ADDR_STAT;
                                    wdata_q    <= '0;
                                    poll_cnt_q <= '0;
                                end
                                S_POLL: begin
                                    if (sdata_rd[1]) begin
                                        ok_q    <= sdata_rd[0];
                                        state_q <= S_RD_W;
                                        saddr_q <= c_ADDR_W;
                                    end else if (poll_cnt_q == PW'(POLL_MAX - 1)) begin
                                        res_w_q   <= '0;
                                        res_l_q   <= '0;
                                        res_ok_q  <= 1'b0;
                                        res_err_q <= 1'b1;
                                        done_q    <= gnt_q;
                                        state_q   <= S_DONE;
                                        saddr_q   <= '0;
                                    end else begin
                                        poll_cnt_q <= poll_cnt_q + PW'(1);
                                        gap_cnt_q  <= '0;
                                        state_q    <= (POLL_GAP == 0) ? S_POLL : S_GAP;
                                        saddr_q    <= (POLL_GAP == 0) ? c_ADDR_STAT : 16'h0000;
                                    end
                                end
                                S_RD_W: begin
                                    word_q  <= sdata_rd;
                                    state_q <= S_RD_L;
                                    saddr_q <= c_ADDR_L;
                                end
                                default: begin
                                    res_w_q   <= word_q;
                                    res_l_q   <= sdata_rd[23:0];
                                    res_ok_q  <= ok_q;
                                    res_err_q <= 1'b0;
                                    done_q    <= gnt_q;
                                    state_q   <= S_DONE;
                                    saddr_q   <= '0;
                                end
                            endcase
                        end
                    endcase
                end

                S_GAP: begin
                    if (gap_cnt_q == GW'(POLL_GAP - 1)) begin
                        state_q <= S_POLL;
                        phase_q <= PH_SETUP;
                        saddr_q <= c_ADDR_STAT;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GW'(1);
                    end
                end

                S_DONE: begin
                    gnt_q   <= 2'b00;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                    gnt_q   <= 2'b00;
                    saddr_q <= '0;
                    wdata_q <= '0;
                    swr_q   <= 1'b0;
                    srd_q   <= 1'b0;
                end
            endcase
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign res_w    = res_w_q;
    assign res_l    = res_l_q;
    assign res_ok   = res_ok_q;
    assign res_err  = res_err_q;
    assign saddress = saddr_q;
    assign swr      = swr_q;
    assign srd      = srd_q;
    assign sdata_wr = wdata_q;

endmodule
`default_nettype wire

// File: doc/mult_job_scheduler.md
MULT_JOB_SCHEDULER -- requirements
Module: mult_job_scheduler

Interface
REQ-001 Parameter POLL_MAX, default 16: maximum status polls per job before timeout.
REQ-002 Parameter POLL_GAP, default 2: idle cycles between consecutive status polls.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 n_reset  in  1  asynchronous active-low reset.
REQ-006 req  in  2  job request, bit i = requester i.
REQ-007 op_a1  in  48  first operand, requester i at [24i+23:24i].
REQ-008 op_a2  in  48  second operand, same packing.
REQ-009 gnt  out  2  one-hot grant, held for the whole job.
REQ-010 done  out  2  one-cycle completion pulse to the granted requester.
REQ-011 res_w  out  32  product low word, read from 0x0390.
REQ-012 res_l  out  24  ones count, read from 0x0398.
REQ-013 res_ok  out  1  status bit 0 (product fits 32 bits).
REQ-014 res_err  out  1  poll timeout flag.
REQ-015 saddress  out  16  peripheral address.
REQ-016 swr, srd  out  1 each  peripheral write/read strobes.
REQ-017 sdata_wr  out  32  peripheral write data.
REQ-018 sdata_rd  in  32  peripheral read data.

Function
REQ-019 States SHALL be IDLE, WR_A1, WR_A2, WR_GO, POLL, GAP, RD_W, RD_L, DONE.
REQ-020 Each bus transaction SHALL take 3 cycles: SETUP (address/data driven, strobe low), STROBE (strobe high), HOLD (strobe low, address/data held).
REQ-021 Read data SHALL be sampled from sdata_rd in the HOLD cycle.
REQ-022 Outside transactions, saddress, sdata_wr, swr and srd SHALL be 0; swr and srd never high together.
REQ-023 In IDLE with any req bit set, the block SHALL grant on the next edge, latch both operands of the winner, and enter WR_A1.
REQ-024 Arbitration SHALL be round-robin: on simultaneous requests, grant the requester not served last; after reset, requester 0 wins.
REQ-025 Sequence: write op_a1 to 0x037F, op_a2 to 0x0388, 0x00000000 to 0x03A0, then read 0x03A0.
REQ-026 Operands SHALL be zero-extended to 32 bits on sdata_wr.
REQ-027 If status bit 1 is 1, the block SHALL latch res_ok = bit 0 and proceed to RD_W, then RD_L; otherwise it SHALL wait POLL_GAP cycles in GAP and poll again.
REQ-028 After POLL_MAX polls without status bit 1 set, the block SHALL skip the reads, set res_err = 1 and res_w = res_l = res_ok = 0.
REQ-029 Latency: with gnt first high in cycle 0 and ready on the first poll, done SHALL pulse in cycle 18; each extra poll adds 3 + POLL_GAP cycles.
REQ-030 In DONE, the block SHALL pulse done for the granted requester, drop gnt on the next edge, and return to IDLE; no new grant in the DONE cycle.
REQ-031 res_* SHALL update only at job end and hold until the next job ends; res_err SHALL clear on a successful job.
REQ-032 A req deasserted mid-job SHALL NOT abort it; done still pulses.
REQ-033 A req bit that drops before grant SHALL be ignored.
REQ-034 Operand changes after grant SHALL NOT affect the running job.

Reset
REQ-035 On n_reset low, all outputs SHALL go to 0 immediately, state to IDLE, and the round-robin pointer to favour requester 0.
REQ-036 A job in flight at reset SHALL be abandoned without a done pulse.
REQ-037 Operation SHALL resume on the first clock edge after reset deasserts.

Verification
REQ-038 req=01, a1=3, a2=5, status 0x3 on first poll -> writes to 0x037F/0x0388/0x03A0 with 3-cycle spacing; res_w=15; done=01 in cycle 18.
REQ-039 req=11 held over two jobs -> grant order 01, 10, 01; no grant in any DONE cycle.
REQ-040 Status 0x1 returned twice, then 0x2 -> 3 polls with 2-cycle gaps; done in cycle 28; res_ok=0.
REQ-041 Status never ready -> exactly 16 polls; then res_err=1, res_w=0, no reads of 0x0390/0x0398.
REQ-042 n_reset pulsed low during WR_GO strobe -> swr falls at once; no done; the next req=10 is granted requester 1.
